rvv_backend_lsu_remap_pipe: RTL

Parametrised, registered successor to the combinational LSU remap stage. It pairs the heads of the LSU map-info FIFO and the LSU result FIFO across NUM_CH read ports and pops them strictly in order. It registers merged results into per-channel output slots toward the ROB. Traps are captured in a dedicated register, with a state machine that stalls the pipe until the ROB takes the trap.

---
 rtl/rvv_backend_lsu_remap_pipe_pkg.sv | 54 +++++
 rtl/rvv_backend_lsu_remap_slot.sv | 30 +++
 rtl/rvv_backend_lsu_remap_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rvv_backend_lsu_remap_pipe_pkg.sv
// Shared types for the registered LSU remap pipe: map info, LSU result,
// ROB result payload and the remap trap FSM states.
package rvv_backend_lsu_remap_pipe_pkg;

    localparam int NUM_LSU             = 2;
    localparam int ROB_DEPTH_WIDTH     = 4;
    localparam int VLEN                = 32;
    localparam int VLENB               = VLEN / 8;
    localparam int REGFILE_INDEX_WIDTH = 5;

    typedef enum logic {
        IS_LOAD  = 1'b0,
        IS_STORE = 1'b1
    } LSU_CLASS_e;

    typedef enum logic {
        IDLE      = 1'b0,
        TRAP_HOLD = 1'b1
    } LSU_REMAP_STATE_e;

    typedef struct packed {
        logic                           valid;
        logic [ROB_DEPTH_WIDTH-1:0]     rob_entry;
        LSU_CLASS_e                     lsu_class;
        logic [REGFILE_INDEX_WIDTH-1:0] vregfile_write_addr;
`ifdef TB_SUPPORT
        logic [31:0]                    uop_pc;
`endif
    } LSU_MAP_INFO_t;

    typedef struct packed {
        logic [REGFILE_INDEX_WIDTH-1:0] vregfile_write_addr;
        logic [VLEN-1:0]                vregfile_write_data;
        logic                           vregfile_write_valid;
        logic                           lsu_vstore_last;
        logic                           trap_valid;
    } UOP_LSU_t;

    typedef struct packed {
        logic [ROB_DEPTH_WIDTH-1:0] rob_entry;
        logic [VLEN-1:0]            w_data;
        logic                       w_valid;
        logic [VLENB-1:0]           vsaturate;
`ifdef TB_SUPPORT
        logic [31:0]                uop_pc;
`endif
    } PU2ROB_t;

    // True when v is a prefix of ones starting at bit 0 (including all-zero).
    function automatic logic is_thermo(input logic [31:0] v);
        return (v & (v + 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/rvv_backend_lsu_remap_slot.sv
// One ROB result output register with valid/ready handshake; a slot that is
// being accepted this cycle may be reloaded on the same edge.
module rvv_backend_lsu_remap_slot
    import rvv_backend_lsu_remap_pipe_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  PU2ROB_t din,
    input  logic    ready,
    output logic    valid,
    output PU2ROB_t dout,
    output logic    free
);

    assign free = !valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rvv_backend_lsu_remap_pipe.sv
// Registered LSU remap: pairs map-info and LSU-result FIFO heads in order,
// registers merged results per channel and holds the pipe on a trap.
module rvv_backend_lsu_remap_pipe
    import rvv_backend_lsu_remap_pipe_pkg::*;
#(
    parameter int NUM_CH    = NUM_LSU,
    parameter int ROB_W     = ROB_DEPTH_WIDTH,
    parameter bit CHK_WADDR = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  LSU_MAP_INFO_t [NUM_CH-1:0]     mapinfo,
    input  logic          [NUM_CH-1:0]     mapinfo_avail,
    input  UOP_LSU_t      [NUM_CH-1:0]     lsu_res,
    input  logic          [NUM_CH-1:0]     lsu_res_avail,
    output logic          [NUM_CH-1:0]     pop_mapinfo,
    output logic          [NUM_CH-1:0]     pop_lsu_res,
    output logic          [NUM_CH-1:0]     result_valid_lsu2rob,
    output PU2ROB_t       [NUM_CH-1:0]     result_lsu2rob,
    input  logic          [NUM_CH-1:0]     result_ready_rob2lsu,
    output logic                           trap_valid_rmp2rob,
    output logic          [ROB_W-1:0]      trap_rob_entry_rmp2rob,
    input  logic                           trap_ready_rob2rmp,
    output logic                           busy
);

    LSU_REMAP_STATE_e        state, state_nxt;
    logic [NUM_CH-1:0]       pair, elig, trap, slot_free, slot_load, pop;
    PU2ROB_t [NUM_CH-1:0]    slot_din;
    logic                    take_trap;
    logic [ROB_W-1:0]        trap_entry_nxt;

    always_comb begin
        pair           = '0;
        elig           = '0;
        trap           = '0;
        pop            = '0;
        slot_din       = '0;
        take_trap      = 1'b0;
        trap_entry_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pair[i] = mapinfo_avail[i] & lsu_res_avail[i] & mapinfo[i].valid;
            trap[i] = pair[i] & lsu_res[i].trap_valid;
            elig[i] = pair[i] & !lsu_res[i].trap_valid &
                      (((mapinfo[i].lsu_class == IS_LOAD) & lsu_res[i].vregfile_write_valid) |
                       ((mapinfo[i].lsu_class == IS_STORE) & lsu_res[i].lsu_vstore_last));
            slot_din[i].rob_entry = mapinfo[i].rob_entry;
            slot_din[i].w_data    = lsu_res[i].vregfile_write_data;
            slot_din[i].w_valid   = (mapinfo[i].lsu_class == IS_LOAD) &
                                    lsu_res[i].vregfile_write_valid &
                                    (!CHK_WADDR |
                                     (lsu_res[i].vregfile_write_addr == mapinfo[i].vregfile_write_addr));
            slot_din[i].vsaturate = '0;
`ifdef TB_SUPPORT
            slot_din[i].uop_pc    = mapinfo[i].uop_pc;
`endif
        end
        // Strict in-order prefix; a trap ends the prefix after itself.
        pop[0] = rst_n & (state == IDLE) & ((elig[0] & slot_free[0]) | trap[0]);
        for (int i = 1; i < NUM_CH; i++) begin
            pop[i] = pop[i-1] & !trap[i-1] & ((elig[i] & slot_free[i]) | trap[i]);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pop[i] & trap[i]) begin
                take_trap      = 1'b1;
                trap_entry_nxt = ROB_W'(mapinfo[i].rob_entry);
            end
        end
    end

    assign slot_load   = pop & elig;
    assign pop_mapinfo = pop;
    assign pop_lsu_res = pop;

    // Stage p1: per-channel output registers toward the ROB.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        rvv_backend_lsu_remap_slot u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (slot_load[g]),
            .din   (slot_din[g]),
            .ready (result_ready_rob2lsu[g]),
            .valid (result_valid_lsu2rob[g]),
            .dout  (result_lsu2rob[g]),
            .free  (slot_free[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (take_trap)          state_nxt = TRAP_HOLD;
            TRAP_HOLD: if (trap_ready_rob2rmp) state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_valid_rmp2rob     <= 1'b0;
            trap_rob_entry_rmp2rob <= '0;
        end else if (take_trap) begin
            trap_valid_rmp2rob     <= 1'b1;
            trap_rob_entry_rmp2rob <= trap_entry_nxt;
        end else if ((state == TRAP_HOLD) & trap_ready_rob2rmp) begin
            trap_valid_rmp2rob     <= 1'b0;
        end
    end

    assign busy = (|result_valid_lsu2rob) | (state != IDLE);

    a_pop_thermo: assert property (@(posedge clk) disable iff (!rst_n)
        is_thermo(32'(pop)));
    a_pop_avail: assert property (@(posedge clk) disable iff (!rst_n)
        (pop & ~(mapinfo_avail & lsu_res_avail)) == '0);
    a_avail_thermo: assert property (@(posedge clk) disable iff (!rst_n)
        is_thermo(32'(mapinfo_avail)) && is_thermo(32'(lsu_res_avail)));
    a_no_pop_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state == TRAP_HOLD) |-> (pop == '0));
    a_trap_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (trap_valid_rmp2rob && !trap_ready_rob2rmp) |=>
        (trap_valid_rmp2rob && $stable(trap_rob_entry_rmp2rob)));

endmodule
